isqrt_seq_responder: RTL and testbench

ISQRT_SEQ_RESPONDER -- requirements
Module: isqrt_seq_responder

---
 rtl/isqrt_seq_responder_if.sv | 13 +
 rtl/isqrt_seq_responder.sv | 145 ++++++++++++++
 tb/tb_isqrt_seq_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/isqrt_seq_responder_if.sv
// Request/result bundle for the sequential integer square-root responder.
// Valid-only request side (no ready); a one-cycle strobe carries each result back.
interface isqrt_seq_responder_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  logic        busy;
  logic        ovf;

  modport master (output x_vld, x, input y_vld, y, busy, ovf);
  modport slave  (input x_vld, x, output y_vld, y, busy, ovf);
endinterface

// File: rtl/isqrt_seq_responder.sv
// Sequential floor(sqrt(x)) engine: restoring digit-by-digit root, two radicand
// bits per cycle, fed by a small request queue with same-cycle bypass.
//
// state | meaning
// IDLE  | no computation in flight, waiting for a pending request
// CALC  | 16 iterations, one root bit per cycle, MSB pair first
// DONE  | result strobe cycle; may start the next request immediately
module isqrt_seq_responder #(
  parameter int FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  isqrt_seq_responder_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    iter_q, iter_d;
  logic [31:0]   rad_q, rad_d;
  logic [17:0]   rem_q, rem_d;
  logic [15:0]   root_q, root_d;
  logic [15:0]   y_q, y_d;
  logic          y_vld_q, y_vld_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          empty, full, start, pop, byp, push;
  logic [19:0]   rem_sh, trial;

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    y_d      = y_q;
    y_vld_d  = 1'b0;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    empty = (cnt_q == '0);
    full  = (cnt_q == CW'(FIFO_DEPTH));
    // Queue head wins over bypass so arrival order is preserved.
    start = (state_q != CALC) && (!empty || bus.x_vld);
    pop   = start && !empty;
    byp   = start && empty;
    push  = bus.x_vld && !byp && (!full || pop);
    if (bus.x_vld && !byp && full && !pop) ovf_d = 1'b1;

    rem_sh = {rem_q, rad_q[31:30]};
    trial  = {2'b00, root_q, 2'b01};

    case (state_q)
      CALC: begin
        rad_d = {rad_q[29:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = 18'(rem_sh - trial);
          root_d = {root_q[14:0], 1'b1};
        end else begin
          rem_d  = rem_sh[17:0];
          root_d = {root_q[14:0], 1'b0};
        end
        if (iter_q == 4'd0) begin
          state_d = DONE;
          y_vld_d = 1'b1;
          y_d     = root_d;
        end else begin
          iter_d = iter_q - 4'd1;
        end
      end
      default: begin
        if (start) begin
          state_d = CALC;
          iter_d  = 4'd15;
          rad_d   = empty ? bus.x : mem_q[rd_ptr_q];
          rem_d   = '0;
          root_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.x;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    busy_d = (state_d != IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      y_q      <= '0;
      y_vld_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      y_q      <= y_d;
      y_vld_q  <= y_vld_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.y_vld = y_vld_q;
  assign bus.y     = y_q;
  assign bus.busy  = busy_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_isqrt_seq_responder.sv
// Scoreboard bench for isqrt_seq_responder: a timing/acceptance model predicts
// each result value and its strobe cycle; a negedge monitor pops and compares.
module tb_isqrt_seq_responder;
  localparam int DEPTH = 2;

  typedef struct {
    logic [15:0] y;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  isqrt_seq_responder_if bus();

  isqrt_seq_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   q_starts[$];
  int   last_y = -1000;
  bit   model_ovf = 1'b0;
  exp_t mon_e;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint lv, r;
    lv = longint'(v);
    r  = longint'($floor($sqrt(real'(lv))));
    while (r * r > lv) r--;
    while ((r + 1) * (r + 1) <= lv) r++;
    return r[15:0];
  endfunction

  // A request starts once the engine is free (it may start in the previous
  // result's strobe cycle); anything not starting at once waits in the queue.
  function automatic void model_accept(input int t, input logic [31:0] xv);
    int   s;
    bit   popping;
    exp_t em;
    popping = 1'b0;
    for (int i = q_starts.size() - 1; i >= 0; i--)
      if (q_starts[i] < t) q_starts.delete(i);
    foreach (q_starts[i]) if (q_starts[i] == t) popping = 1'b1;
    if (q_starts.size() >= DEPTH && !popping) begin
      model_ovf = 1'b1;
      return;
    end
    s = (last_y > t) ? last_y : t;
    if (s > t) q_starts.push_back(s);
    last_y = s + 17;
    em.y   = ref_sqrt(xv);
    em.cyc = last_y;
    sb.push_back(em);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.y_vld === 1'b1) begin
      if (sb.size() == 0) begin
        chk("y_vld_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("y_value", bus.y, mon_e.y);
        chk("y_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk("busy", bus.busy, (cyc <= last_y) ? 1 : 0);
  endtask

  task automatic issue(input logic [31:0] xv);
    model_accept(cyc, xv);
    bus.x_vld = 1'b1;
    bus.x     = xv;
    @(posedge clk);
    #1;
    bus.x_vld = 1'b0;
    bus.x     = $urandom;
    chk("ovf", bus.ovf, model_ovf);
    chk("busy", bus.busy, (cyc <= last_y) ? 1 : 0);
  endtask

  task automatic wait_yvld();
    for (int k = 0; k < 40; k++) begin
      if (bus.y_vld === 1'b1) return;
      tick();
    end
    chk("y_vld_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_pending", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_y_vld", bus.y_vld, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    sb.delete();
    q_starts.delete();
    last_y    = -1000;
    model_ovf = 1'b0;
    bus.x_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] singles [6];
    logic [31:0] xv;
    longint      r;

    singles = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF, 32'h4000_0000};
    bus.x_vld = 1'b0;
    bus.x     = '0;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("init_y_vld", bus.y_vld, 0);
    chk("init_y", bus.y, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_ovf", bus.ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (singles[i]) begin
      issue(singles[i]);
      repeat (25) tick();
    end

    issue(32'd9);
    wait_yvld();
    issue(32'(ref_sqrt(32'd9)) + 32'd100);
    wait_yvld();
    issue(32'(ref_sqrt(32'd103)) + 32'd100);
    drain();

    issue(32'd4);
    issue(32'd25);
    issue(32'd100);
    drain();

    issue(32'hFFFF_FFFF);
    repeat (7) tick();
    do_reset();
    issue(32'd49);
    drain();

    issue(32'd1);
    issue(32'd4);
    issue(32'd9);
    issue(32'd16);
    drain();
    chk("ovf_sticky", bus.ovf, 1);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      r = longint'($urandom_range(1, 65535));
      case ($urandom_range(0, 4))
        0:       xv = $urandom;
        1:       xv = $urandom_range(0, 300);
        2:       xv = 32'(r * r);
        3:       xv = 32'(r * r - 1);
        default: xv = 32'hFFFF_FFFF - $urandom_range(0, 1000);
      endcase
      issue(xv);
      repeat ($urandom_range(0, 20)) tick();
    end
    drain();
    chk("ovf_final", bus.ovf, model_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
